// File: rtl/prog1_pkg.sv
// Shared types, defaults and the SECDED encode function
// for program 1 (Hamming encode).
package prog1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } p1_state_t;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;

  function automatic logic [15:0] hamming16(
    input logic [11:1] d
  );
    logic p8;
    logic p4;
    logic p2;
    logic p1;
    logic p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6]
       ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5]
       ^ d[4] ^ d[2] ^ d[1];
    // p0 covers every other codeword bit
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4,
            d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc16.sv
// Combinational 11-bit message to 16-bit SECDED codeword.
// Kept separate so the decode work can reuse it.
module hamming_enc16
  import prog1_pkg::*;
(
  input  logic [10:0] d,
  output logic [15:0] cw
);

  assign cw = hamming16(d);

endmodule

// File: rtl/hamming_enc_ctrl.sv
// Program 1 sequencer: reads 15 messages, writes their
// SECDED codewords back, then holds done.
module hamming_enc_ctrl #(
  parameter int NUM_MSG  = prog1_pkg::NUM_MSG,
  parameter int SRC_BASE = prog1_pkg::SRC_BASE,
  parameter int DST_BASE = prog1_pkg::DST_BASE,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] dm_addr,
  output logic          dm_we,
  output logic [7:0]    dm_wdata,
  input  logic [7:0]    dm_rdata
);

  import prog1_pkg::*;

  localparam int IW =
    (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  p1_state_t     state;
  p1_state_t     state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [7:0]    lo_reg;
  logic [2:0]    hi_reg;
  logic [15:0]   cw;
  logic [AW-1:0] off;
  logic [AW-1:0] src_a;
  logic [AW-1:0] dst_a;
  logic          last;

  // Each message occupies a byte pair
  assign off   = AW'({idx, 1'b0});
  assign src_a = AW'(SRC_BASE) + off;
  assign dst_a = AW'(DST_BASE) + off;
  assign last  = (idx == IW'(NUM_MSG - 1));

  hamming_enc16 u_enc (
    .d  ({hi_reg, lo_reg}),
    .cw (cw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_reg <= '0;
      hi_reg <= '0;
    end else begin
      if (state == RD_LO)
        lo_reg <= dm_rdata;
      if (state == RD_HI)
        hi_reg <= dm_rdata[2:0];
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    done     = 1'b0;
    busy     = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          idx_n   = '0;
          state_n = RD_LO;
        end
      end
      RD_LO: begin
        busy    = 1'b1;
        dm_addr = src_a;
        state_n = RD_HI;
      end
      RD_HI: begin
        busy    = 1'b1;
        dm_addr = src_a + AW'(1);
        state_n = WR_LO;
      end
      WR_LO: begin
        busy     = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = dst_a;
        dm_wdata = cw[7:0];
        state_n  = WR_HI;
      end
      WR_HI: begin
        busy     = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = dst_a + AW'(1);
        dm_wdata = cw[15:8];
        if (last) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = RD_LO;
        end
      end
      DONE: begin
        done = 1'b1;
        if (req) begin
          idx_n   = '0;
          state_n = RD_LO;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_ctrl.sv
// Self-checking bench for hamming_enc_ctrl against a
// position-based Hamming reference and a byte memory.
module tb_hamming_enc_ctrl;

  localparam int NM  = 15;
  localparam int SRC = 0;
  localparam int DST = 30;

  logic       clk;
  logic       reset;
  logic       req;
  logic       done;
  logic       busy;
  logic [7:0] dm_addr;
  logic       dm_we;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_data;

  logic [10:0] msg  [NM];
  logic [7:0]  hib  [NM];
  logic [7:0]  save [2*NM];

  int n_chk;
  int n_fail;

  hamming_enc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .busy     (busy),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we)
      mem[dm_addr] <= dm_wdata;
    else if (tb_we)
      mem[tb_addr] <= tb_data;
  end

  // Classic Hamming: data in non-power-of-two positions,
  // parity at 1,2,4,8, overall parity at position 0.
  function automatic logic [15:0] ref_cw(
    input logic [10:0] m
  );
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = m[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < 16; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b))
          par = par ^ c[p];
      c[1 << b] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic poke(input int a, input logic [7:0] v);
    tb_addr = 8'(a);
    tb_data = v;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic load_msgs();
    for (int i = 0; i < NM; i++) begin
      poke(SRC + 2*i, msg[i][7:0]);
      poke(SRC + 2*i + 1, hib[i]);
    end
  endtask

  task automatic fill_dst(input logic [7:0] v);
    for (int i = 0; i < 2*NM; i++)
      poke(DST + i, v);
  endtask

  task automatic rand_msgs();
    for (int i = 0; i < NM; i++) begin
      msg[i] = 11'($urandom_range(0, 2047));
      hib[i] = {5'($urandom_range(0, 31)), msg[i][10:8]};
    end
  endtask

  // Pulse req for one edge, wait for done, check latency
  task automatic run_and_wait(input string nm);
    int cyc;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    n_chk++;
    if (busy !== 1'b1 || dm_addr !== 8'(SRC)) begin
      n_fail++;
      $display("FAIL %s_first_rd busy=%b addr=%0d want 1/%0d",
               nm, busy, dm_addr, SRC);
    end
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (cyc != 4*NM + 1) begin
      n_fail++;
      $display("FAIL %s_done_latency got %0d want %0d",
               nm, cyc, 4*NM + 1);
    end
  endtask

  task automatic check_out(input string nm);
    logic [15:0] e;
    for (int i = 0; i < NM; i++) begin
      e = ref_cw(msg[i]);
      n_chk++;
      if ({mem[DST+2*i+1], mem[DST+2*i]} !== e) begin
        n_fail++;
        $display("FAIL %s_cw%0d got %h want %h", nm, i,
                 {mem[DST+2*i+1], mem[DST+2*i]}, e);
      end
      n_chk++;
      if (mem[SRC+2*i] !== msg[i][7:0] ||
          mem[SRC+2*i+1] !== hib[i]) begin
        n_fail++;
        $display("FAIL %s_src%0d got %h%h want %h%h", nm, i,
                 mem[SRC+2*i+1], mem[SRC+2*i],
                 hib[i], msg[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({done, busy, dm_we, dm_addr, dm_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %b%b%b %h %h want 0",
               done, busy, dm_we, dm_addr, dm_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold done=%b busy=%b want 0/0",
               done, busy);
    end
  endtask

  task automatic test_directed();
    logic [15:0] want [4];
    want[0] = 16'h0000;
    want[1] = 16'hFFFF;
    want[2] = 16'h000F;
    want[3] = 16'h8117;
    rand_msgs();
    msg[0] = 11'h000; hib[0] = 8'hF8;
    msg[1] = 11'h7FF; hib[1] = 8'h07;
    msg[2] = 11'h001; hib[2] = 8'h00;
    msg[3] = 11'h400; hib[3] = 8'h04;
    load_msgs();
    fill_dst(8'hAA);
    run_and_wait("directed");
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({mem[DST+2*i+1], mem[DST+2*i]} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_cw%0d got %h want %h", i,
                 {mem[DST+2*i+1], mem[DST+2*i]}, want[i]);
      end
    end
    check_out("directed");
    repeat (3) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || dm_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold done=%b we=%b busy=%b want 1/0/0",
               done, dm_we, busy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      rand_msgs();
      load_msgs();
      fill_dst(8'h5A);
      run_and_wait("random");
      check_out("random");
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    rand_msgs();
    load_msgs();
    fill_dst(8'hAA);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    while (cyc < 23) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (dm_we !== 1'b1 || dm_addr !== 8'(DST + 10)) begin
      n_fail++;
      $display("FAIL abort_wrlo we=%b addr=%0d want 1/%0d",
               dm_we, dm_addr, DST + 10);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || dm_we !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async busy=%b we=%b done=%b want 0",
               busy, dm_we, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle done=%b busy=%b want 0/0",
               done, busy);
    end
    for (int i = 0; i < NM; i++) begin
      logic [15:0] e;
      e = (i < 5) ? ref_cw(msg[i]) : 16'hAAAA;
      n_chk++;
      if ({mem[DST+2*i+1], mem[DST+2*i]} !== e) begin
        n_fail++;
        $display("FAIL abort_mem%0d got %h want %h", i,
                 {mem[DST+2*i+1], mem[DST+2*i]}, e);
      end
    end
    run_and_wait("rerun");
    check_out("rerun");
  endtask

  task automatic test_restart_done();
    for (int i = 0; i < 2*NM; i++)
      save[i] = mem[DST + i];
    fill_dst(8'h33);
    run_and_wait("restart");
    for (int i = 0; i < 2*NM; i++) begin
      n_chk++;
      if (mem[DST + i] !== save[i]) begin
        n_fail++;
        $display("FAIL restart_byte%0d got %h want %h", i,
                 mem[DST + i], save[i]);
      end
    end
  endtask

  task automatic test_done_drop();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_drop done=%b busy=%b want 0/1",
               done, busy);
    end
    repeat (70) @(negedge clk);
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_again done=%b want 1", done);
    end
    check_out("drop");
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    req    = 1'b0;
    tb_we  = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    for (int i = 0; i < 256; i++)
      mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_restart_done();
    test_done_drop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
